// File: rtl/qpmm_iter_pkg.sv
// qpmm_iter_pkg
// Shared definitions for the iterative Montgomery multiplier: the digit
// count helper, default-width operand typedefs, the controller state
// encoding and the BN254 base-field prime used by the Fp/Fp2 towers.
// No ports (package).
package qpmm_iter_pkg;

  // Default configuration, matching the BN254 tower datapath.
  localparam int QPMM_WIDTH = 256;
  localparam int QPMM_K     = 16;

  // BN254 base-field modulus p.
  localparam logic [QPMM_WIDTH-1:0] BN254_P =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  // Number of K-bit digits needed to cover a WIDTH-bit operand; the last
  // digit is zero-padded when K does not divide WIDTH.
  function automatic int qpmm_nw(input int width, input int k);
    return (width + k - 1) / k;
  endfunction

  typedef logic [QPMM_WIDTH-1:0] qpmm_iter_op_t;
  typedef logic [QPMM_WIDTH+1:0] qpmm_iter_acc_t;
  typedef logic [QPMM_K-1:0]     qpmm_iter_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FSUB = 2'd2,
    DONE = 2'd3
  } qpmm_iter_state_t;

endpackage

// File: rtl/qpmm_iter_row.sv
// qpmm_iter_row
// One combinational CIOS row of the Montgomery product: folds a single
// K-bit digit of A into the running accumulator and divides by 2^K.
// Ports:
//   s      - accumulator in (WIDTH+2 bits, < 2M)
//   a      - current K-bit digit of A
//   b      - multiplier B
//   m      - modulus M (odd)
//   minv   - -M^-1 mod 2^K
//   s_next - (s + a*B + q*M) / 2^K, again < 2M
//   q      - quotient digit chosen to clear the low K bits
module qpmm_iter_row
  import qpmm_iter_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int K     = 16
) (
  input  logic [WIDTH+1:0] s,
  input  logic [K-1:0]     a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic [K-1:0]     minv,
  output logic [WIDTH+1:0] s_next,
  output logic [K-1:0]     q
);

  // s < 2^(WIDTH+1) and a*B, q*M < 2^(WIDTH+K), so the sum fits in
  // WIDTH+K+2 bits without overflow.
  localparam int TW = WIDTH + K + 2;

  logic [TW-1:0] t;
  logic [TW-1:0] u;

  // q makes t + q*M divisible by 2^K, so the shift drops only zero bits.
  always_comb begin
    t      = TW'(s) + TW'(a) * TW'(b);
    q      = t[K-1:0] * minv;
    u      = t + TW'(q) * TW'(m);
    s_next = (WIDTH+2)'(u >> K);
  end

endmodule

// File: rtl/qpmm_iter.sv
// qpmm_iter
// Iterative digit-serial Montgomery multiplier, Z = A*B*R^-1 mod M with
// R = 2^(K*NW). A single CIOS row is reused for NW cycles, optionally
// followed by one conditional-subtract cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cfg_we/cfg_m/cfg_minv - modulus and -M^-1 mod 2^K load (IDLE only)
//   in_valid/in_ready/in_a/in_b - operand handshake
//   out_valid/out_ready/out_z   - result handshake (out_z is WIDTH+1 bits)
//   busy                - operation in flight or result pending
module qpmm_iter
  import qpmm_iter_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int K         = 16,
  parameter int FINAL_SUB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_m,
  input  logic [K-1:0]     cfg_minv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_z,
  output logic             busy
);

  localparam int NW = qpmm_nw(WIDTH, K);
  localparam int AW = NW * K;
  localparam int SW = WIDTH + 2;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

  qpmm_iter_state_t state;

  logic [AW-1:0]    a_sr;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [K-1:0]     minv_reg;
  logic [SW-1:0]    s_reg;
  logic [CW-1:0]    cnt;

  logic [SW-1:0]    row_s_next;
  // The quotient digit is not needed by the controller; it is brought out
  // of the row only so it can be observed alongside the accumulator.
  logic [K-1:0]     row_q_unused;

  logic             s_ge_m;
  logic [SW-1:0]    s_minus_m;

  qpmm_iter_row #(
    .WIDTH (WIDTH),
    .K     (K)
  ) u_row (
    .s      (s_reg),
    .a      (a_sr[K-1:0]),
    .b      (b_reg),
    .m      (m_reg),
    .minv   (minv_reg),
    .s_next (row_s_next),
    .q      (row_q_unused)
  );

  // Final reduction: S < 2M, so one subtraction lands in [0, M).
  always_comb begin
    s_ge_m    = (s_reg >= {2'b00, m_reg});
    s_minus_m = s_reg - {2'b00, m_reg};
  end

  // Controller and datapath registers. All handshake outputs are registered
  // so in_ready/out_valid/busy change only on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_z     <= '0;
      busy      <= 1'b0;
      m_reg     <= '0;
      minv_reg  <= '0;
      cnt       <= '0;
      a_sr      <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // A config write in the same cycle as an accept is seen by that
          // operation, because the row only reads m_reg/minv_reg from ITER on.
          if (cfg_we) begin
            m_reg    <= cfg_m;
            minv_reg <= cfg_minv;
          end
          if (in_valid) begin
            a_sr     <= AW'(in_a);
            b_reg    <= in_b;
            s_reg    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ITER;
          end
        end
        ITER: begin
          s_reg <= row_s_next;
          a_sr  <= a_sr >> K;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (FINAL_SUB != 0) begin
              state <= FSUB;
            end else begin
              out_z     <= (WIDTH+1)'(row_s_next);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        FSUB: begin
          out_z     <= (WIDTH+1)'(s_ge_m ? s_minus_m : s_reg);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpmm_iter.sv
// tb_qpmm_iter
// Self-checking bench for qpmm_iter at WIDTH=16, K=8 with one FINAL_SUB=1
// and one FINAL_SUB=0 instance. Expected results come from a modular
// arithmetic model (A*B*R^-1 mod M) or hand-computed literals.
module tb_qpmm_iter;

  localparam int     W  = 16;
  localparam int     K  = 8;
  localparam longint R  = 65536;
  localparam longint M1 = 65521;
  localparam longint M2 = 65519;
  localparam logic [K-1:0] MINV1 = 8'd239;
  localparam logic [K-1:0] MINV2 = 8'd241;

  typedef struct {
    longint z;
    longint m;
    bit     exact;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cfg_m;
  logic [K-1:0] cfg_minv;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic         cfg_we_f, in_valid_f, out_ready_f;
  logic         in_ready_f, out_valid_f, busy_f;
  logic [W:0]   out_z_f;

  logic         cfg_we_r, in_valid_r, out_ready_r;
  logic         in_ready_r, out_valid_r, busy_r;
  logic [W:0]   out_z_r;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint acc_cyc = 0;
  longint model_m_f = 0;
  longint model_m_r = 0;
  exp_t   exp_f[$];
  exp_t   exp_r[$];

  qpmm_iter #(.WIDTH(W), .K(K), .FINAL_SUB(1)) dut_f (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_f), .cfg_m(cfg_m), .cfg_minv(cfg_minv),
    .in_valid(in_valid_f), .in_ready(in_ready_f), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_f), .out_ready(out_ready_f), .out_z(out_z_f), .busy(busy_f)
  );

  qpmm_iter #(.WIDTH(W), .K(K), .FINAL_SUB(0)) dut_r (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_r), .cfg_m(cfg_m), .cfg_minv(cfg_minv),
    .in_valid(in_valid_r), .in_ready(in_ready_r), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_r), .out_ready(out_ready_r), .out_z(out_z_r), .busy(busy_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Modular inverse by extended Euclid.
  function automatic longint mod_inv(input longint x, input longint m);
    longint t0 = 0, t1 = 1, r0 = m, r1 = x % m, qq, tmp;
    while (r1 != 0) begin
      qq  = r0 / r1;
      tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
      tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
    end
    if (t0 < 0) t0 = t0 + m;
    return t0;
  endfunction

  // Reference Montgomery product A*B*R^-1 mod M.
  function automatic longint mont_ref(input longint a, input longint b, input longint m);
    return (((a * b) % m) * mod_inv(R % m, m)) % m;
  endfunction

  task automatic checkEq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit raw);
    return raw ? in_ready_r : in_ready_f;
  endfunction

  function automatic logic vld(input bit raw);
    return raw ? out_valid_r : out_valid_f;
  endfunction

  // Result scoreboard: every cycle a result is presented it must match the
  // oldest accepted operation; it is retired on the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_f) begin
        checks++;
        if (exp_f.size() == 0) begin
          errors++;
          $display("[TB] FAIL result_f: out_z=%0d presented with no pending operation", out_z_f);
        end else if (longint'(out_z_f) != exp_f[0].z) begin
          errors++;
          $display("[TB] FAIL result_f: out_z=%0d, expected %0d", out_z_f, exp_f[0].z);
        end
        checks++;
        if (in_ready_f !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ready_while_valid_f: in_ready=%0b, expected 0", in_ready_f);
        end
        if (out_ready_f && exp_f.size() != 0) void'(exp_f.pop_front());
      end
      if (out_valid_r) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("[TB] FAIL result_r: out_z=%0d presented with no pending operation", out_z_r);
        end else if (exp_r[0].exact ? (longint'(out_z_r) != exp_r[0].z)
                     : (longint'(out_z_r) >= 2 * exp_r[0].m ||
                        (longint'(out_z_r) % exp_r[0].m) != exp_r[0].z)) begin
          errors++;
          $display("[TB] FAIL result_r: out_z=%0d, expected %0d mod %0d and below 2M",
                   out_z_r, exp_r[0].z, exp_r[0].m);
        end
        if (out_ready_r && exp_r.size() != 0) void'(exp_r.pop_front());
      end
    end
  end

  // Write M/minv to one instance while it is idle.
  task automatic loadCfg(input bit raw, input longint m, input logic [K-1:0] minv);
    int n = 0;
    while (!rdy(raw) && n < 40) begin @(negedge clk); n++; end
    checkEq(raw ? "cfg_idle_r" : "cfg_idle_f", rdy(raw), 1);
    cfg_m    = W'(m);
    cfg_minv = minv;
    if (raw) cfg_we_r = 1'b1; else cfg_we_f = 1'b1;
    @(posedge clk);
    if (raw) model_m_r = m; else model_m_f = m;
    #1;
    cfg_we_r = 1'b0;
    cfg_we_f = 1'b0;
  endtask

  // Present one operand pair (optionally with a config write in the same
  // cycle) and queue its expected result; lit >= 0 overrides the model.
  task automatic applyStimulus(input bit raw, input longint a, input longint b,
                               input bit we, input longint m, input logic [K-1:0] minv,
                               input longint lit);
    int   n = 0;
    exp_t e;
    while (!rdy(raw) && n < 40) begin @(negedge clk); n++; end
    checkEq(raw ? "accept_ready_r" : "accept_ready_f", rdy(raw), 1);
    in_a = W'(a);
    in_b = W'(b);
    if (we) begin
      cfg_m    = W'(m);
      cfg_minv = minv;
    end
    if (raw) begin in_valid_r = 1'b1; cfg_we_r = we; end
    else     begin in_valid_f = 1'b1; cfg_we_f = we; end
    @(posedge clk);
    if (we) begin
      if (raw) model_m_r = m; else model_m_f = m;
    end
    e.m     = raw ? model_m_r : model_m_f;
    e.z     = (lit >= 0) ? lit : mont_ref(a, b, e.m);
    e.exact = (lit >= 0) || !raw;
    if (raw) exp_r.push_back(e); else exp_f.push_back(e);
    #1;
    acc_cyc    = cyc;
    in_valid_r = 1'b0;
    in_valid_f = 1'b0;
    cfg_we_r   = 1'b0;
    cfg_we_f   = 1'b0;
  endtask

  // Wait (bounded) for the result, check latency from the accept edge and
  // that the block is idle again on the cycle after the handshake.
  task automatic checkOutput(input bit raw, input int exp_lat);
    int n    = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = vld(raw);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: out_valid=0 after %0d cycles, expected 1", n);
    end else begin
      checkEq(raw ? "latency_r" : "latency_f", cyc - acc_cyc, exp_lat);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkEq(raw ? "idle_return_r" : "idle_return_f", rdy(raw), 1);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int n;

    rst = 1'b1;
    cfg_m = '0; cfg_minv = '0; in_a = '0; in_b = '0;
    cfg_we_f = 0; in_valid_f = 0; out_ready_f = 1;
    cfg_we_r = 0; in_valid_r = 0; out_ready_r = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    checkEq("rst_in_ready_f", in_ready_f, 1);
    checkEq("rst_out_valid_f", out_valid_f, 0);
    checkEq("rst_out_z_f", out_z_f, 0);
    checkEq("rst_busy_f", busy_f, 0);
    checkEq("rst_in_ready_r", in_ready_r, 1);
    checkEq("rst_out_valid_r", out_valid_r, 0);
    checkEq("rst_busy_r", busy_r, 0);

    loadCfg(0, M1, MINV1);
    loadCfg(1, M1, MINV1);

    $display("[TB] A=1 B=15 with row trace");
    applyStimulus(0, 1, 15, 0, 0, 0, 1);
    @(negedge clk);
    checkEq("row0_q", dut_f.row_q_unused, 1);
    @(negedge clk);
    checkEq("row0_s", dut_f.s_reg, 256);
    checkEq("row1_q", dut_f.row_q_unused, 0);
    checkOutput(0, 3);

    $display("[TB] directed literals");
    applyStimulus(0, 65520, 15, 0, 0, 0, 65520);
    checkOutput(0, 3);
    applyStimulus(0, 0, 12345, 0, 0, 0, 0);
    checkOutput(0, 3);
    applyStimulus(0, 65520, 65520, 0, 0, 0, -1);
    checkOutput(0, 3);
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom_range(65520, 0));
      rb = W'($urandom_range(65520, 0));
      applyStimulus(0, ra, rb, 0, 0, 0, -1);
      checkOutput(0, 3);
    end

    $display("[TB] raw-result instance");
    applyStimulus(1, 1, 15, 0, 0, 0, 1);
    checkOutput(1, 2);
    for (int i = 0; i < 5; i++) begin
      ra = W'($urandom_range(65520, 0));
      rb = W'($urandom_range(65520, 0));
      applyStimulus(1, ra, rb, 0, 0, 0, -1);
      checkOutput(1, 2);
    end

    $display("[TB] back-pressure hold");
    out_ready_f = 1'b0;
    applyStimulus(0, 3, 4, 0, 0, 0, -1);
    n = 0;
    while (!out_valid_f && n < 40) begin @(negedge clk); n++; end
    checkEq("hold_valid_seen", out_valid_f, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid_f = 1'b1;
      in_a = 16'd99;
      in_b = 16'd77;
      @(negedge clk);
      checkEq("hold_in_ready", in_ready_f, 0);
      checkEq("hold_out_valid", out_valid_f, 1);
    end
    @(posedge clk);
    #1;
    in_valid_f  = 1'b0;
    out_ready_f = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkEq("release_in_ready", in_ready_f, 1);
    checkEq("release_out_valid", out_valid_f, 0);
    repeat (4) @(negedge clk);
    checkEq("hold_no_extra_op", exp_f.size(), 0);

    $display("[TB] config write during ITER");
    applyStimulus(0, 1234, 5678, 0, 0, 0, -1);
    cfg_m = W'(M2);
    cfg_minv = MINV2;
    cfg_we_f = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 cfg_we_f = 1'b0;
    checkOutput(0, 3);
    applyStimulus(0, 1, 15, 0, 0, 0, 1);
    checkOutput(0, 3);

    $display("[TB] config write with accept");
    applyStimulus(0, 1, 17, 1, M2, MINV2, 1);
    checkOutput(0, 3);
    ra = W'($urandom_range(65518, 0));
    rb = W'($urandom_range(65518, 0));
    applyStimulus(0, ra, rb, 0, 0, 0, -1);
    checkOutput(0, 3);
    loadCfg(0, M1, MINV1);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 5, 7, 0, 0, 0, -1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_f.delete();
    exp_r.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_m_f = 0;
    model_m_r = 0;
    @(negedge clk);
    checkEq("abort_out_valid", out_valid_f, 0);
    checkEq("abort_in_ready", in_ready_f, 1);
    checkEq("abort_busy", busy_f, 0);
    checkEq("abort_out_z", out_z_f, 0);
    repeat (3) @(negedge clk);
    loadCfg(0, M1, MINV1);
    applyStimulus(0, 1, 15, 0, 0, 0, 1);
    checkOutput(0, 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
